fetch_queue_unit: RTL
=====================

Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end for the multi-cycle RISC-V CPU.
- Owns the program counter and issues in-order requests to a pipelined instruction memory.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch queue.
- Delivers instructions to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with queue flush and discard of stale in-flight responses.

Parameters:
XLEN, 32, address/data width.
DEPTH, 4, prefetch queue entries; power of two, >= 2; also the cap on queued plus outstanding fetches.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
redirect_valid  input  1  branch/jump taken; restart fetch at redirect_target.
redirect_target  input  XLEN  new PC; bits [1:0] are ignored and forced to 0.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request.
imem_req_addr  output  XLEN  fetch address.
imem_rsp_valid  input  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
imem_rsp_data  input  XLEN  instruction word.
out_valid  output  1  queue head valid.
out_ready  input  1  decode accepts the head.
out_instr  output  XLEN  head instruction.
out_pc  output  XLEN  PC of the head instruction.
busy  output  1  outstanding count != 0 or discard count != 0.

Behaviour:
Reset (asynchronous, active-high):
- req_pc = rsp_pc = RESET_PC; queue empty; outstanding = discard = 0.
- imem_req_valid = 0 and out_valid = 0 while reset is asserted.

Request side:
- imem_req_valid = !reset && !redirect_valid && (occupancy + outstanding < DEPTH).
- imem_req_addr = req_pc.
- On req handshake: req_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
- Request fields stay stable while valid && !ready, unless a redirect arrives.

Response side (on imem_rsp_valid):
- If discard > 0: drop the word; discard -= 1; outstanding -= 1.
- Otherwise: push {imem_rsp_data, rsp_pc}; rsp_pc += 4; outstanding -= 1.
- The credit rule guarantees no overflow. A push into a full queue is a design error; assert it in simulation.

Output side:
- out_valid = queue not empty; out_instr and out_pc come from the head.
- Pop on out_valid && out_ready.
- No bypass: a response written in cycle N is visible at the output in cycle N+1.
- Simultaneous push and pop is allowed at any occupancy, including full; occupancy is unchanged.

Redirect (sampled at the clock edge):
- Queue flushed (occupancy = 0).
- req_pc = rsp_pc = {redirect_target[XLEN-1:2], 2'b00}.
- discard = outstanding minus 1 if a non-discarded or discarded response also arrives that cycle, so every old-stream response is dropped.
- A response arriving in the redirect cycle is never pushed.
- A pop in the redirect cycle has no additional effect.
- Back-to-back redirects: the latest one wins; discard accumulates correctly.

Latency:
- Zero-wait memory with 1-cycle response: first out_valid 2 cycles after reset deasserts.
- Sustained throughput of 1 instruction per cycle when out_ready = 1.

Reset mid-operation:
- All state returns to the reset values immediately.
- In-flight memory responses arriving after reset release are not discarded; the memory must also be reset.

Test Plan:
- Reset release, ready memory, 1-cycle response, out_ready = 1 -> req addrs 0x0, 0x4, 0x8...; out_valid rises cycle 2; out_pc 0x0, 0x4, 0x8 with matching instr, one per cycle.
- out_ready = 0 with DEPTH = 4 -> queue fills to 4; imem_req_valid drops; no requests beyond addr 0xC; raising out_ready drains 0x0..0xC in order, then fetching resumes at 0x10.
- imem_req_ready stall for 3 cycles -> imem_req_addr held constant, req_pc not advanced, no duplicate or skipped PC at the output.
- 3-cycle memory latency, 2 requests outstanding, redirect to 0x103 -> both old responses dropped; next request addr 0x100; first out_pc 0x100; busy clears once discard reaches 0.
- Redirect in the same cycle as a response and a pop -> that response is dropped, queue empty next cycle, discard = remaining outstanding.
- Reset asserted mid-stream with 3 entries queued -> out_valid and imem_req_valid go to 0 asynchronously; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order requests to a
// pipelined instruction memory, queues returned words with their PCs and
// hands them to decode. Redirects flush the queue and discard stale responses.
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;

  logic            req_fire;
  logic            push;
  logic            pop;
  logic            drop;
  logic [SW-1:0]   inflight;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   remaining;

  // Credit check, handshakes and the word-aligned redirect address.
  always_comb begin
    inflight       = SW'(count) + SW'(outstanding);
    imem_req_valid = !reset && !redirect_valid && (inflight < DEPTH_S);
    imem_req_addr  = req_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    out_valid      = (count != '0);
    out_instr      = q_instr[rd_ptr];
    out_pc         = q_pc[rd_ptr];
    push           = imem_rsp_valid && (discard == '0) && !redirect_valid;
    drop           = imem_rsp_valid && (discard != '0);
    pop            = out_valid && out_ready && !redirect_valid;
    busy           = (outstanding != '0) || (discard != '0);
    redirect_pc    = redirect_target & ~XLEN'(3);
    remaining      = outstanding - CW'(imem_rsp_valid);
  end

  // PC, queue pointers and fetch bookkeeping; redirect overrides normal flow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_pc      <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      req_pc      <= redirect_pc;
      rsp_pc      <= redirect_pc;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= remaining;
      discard     <= remaining;
    end else begin
      if (req_fire) begin
        req_pc <= req_pc + XLEN'(4);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (drop) begin
        discard <= discard - CW'(1);
      end
    end
  end

  // Queue storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rsp_data;
      q_pc[wr_ptr]    <= rsp_pc;
    end
  end

  // Credits must make it impossible to push into a full queue without a pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_no_overflow: assert (!(push && !pop && (count == DEPTH_C)));
    end
  end

endmodule
